bsg_manycore_ruche_link_pipe: RTL and testbench

BSG_MANYCORE_RUCHE_LINK_PIPE -- requirements
Module: bsg_manycore_ruche_link_pipe

---
 rtl/bsg_manycore_ruche_link_pipe.sv | 97 +++++++++
 tb/tb_bsg_manycore_ruche_link_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_ruche_link_pipe.sv
// Ruche link pipeline: lane remap followed by stages_p elastic 2-entry FIFOs
// per channel, with saturating per-output-channel stall counters.
module bsg_manycore_ruche_link_pipe #(
  parameter int unsigned width_p           = 8,
  parameter int unsigned ruche_factor_p    = 3,
  parameter int unsigned stages_p          = 1,
  parameter int unsigned rotate_p          = 1,
  parameter int unsigned stall_ctr_width_p = 16,
  localparam int unsigned chan_lp          = 2 * ruche_factor_p
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [chan_lp-1:0]                   valid_i,
  input  logic [chan_lp*width_p-1:0]           data_i,
  output logic [chan_lp-1:0]                   ready_and_o,
  output logic [chan_lp-1:0]                   valid_o,
  output logic [chan_lp*width_p-1:0]           data_o,
  input  logic [chan_lp-1:0]                   ready_and_i,
  input  logic                                 stall_clear_i,
  output logic [chan_lp*stall_ctr_width_p-1:0] stall_cnt_o
);

  localparam int unsigned SW = stall_ctr_width_p;

  // Per-channel handshake chain: index 0 is the mapped input, index stages_p the output.
  logic [stages_p:0]  w_stg_valid [chan_lp];
  logic [stages_p:0]  w_stg_ready [chan_lp];
  logic [width_p-1:0] w_stg_data  [chan_lp][stages_p+1];

  for (genvar c = 0; c < chan_lp; c++) begin : g_chan
    localparam int unsigned lane_lp = c / 2;
    localparam int unsigned dir_lp  = c % 2;
    localparam int unsigned src_lp  = (rotate_p != 0)
                                    ? 2 * ((lane_lp + 1) % ruche_factor_p) + dir_lp
                                    : c;

    assign w_stg_valid[c][0]    = valid_i[src_lp];
    assign w_stg_data[c][0]     = data_i[src_lp*width_p +: width_p];
    assign ready_and_o[src_lp]  = w_stg_ready[c][0];

    for (genvar s = 0; s < stages_p; s++) begin : g_stg
      logic [width_p-1:0] r_mem [2];
      logic               r_wptr;
      logic               r_rptr;
      logic [1:0]         r_count;
      logic               w_enq;
      logic               w_deq;

      // Ready is "not full" only, so it never depends on the upstream valid.
      assign w_enq = w_stg_valid[c][s] && (r_count != 2'd2);
      assign w_deq = (r_count != 2'd0) && w_stg_ready[c][s+1];

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_mem[0] <= '0;
          r_mem[1] <= '0;
          r_wptr   <= 1'b0;
          r_rptr   <= 1'b0;
          r_count  <= 2'd0;
        end else begin
          if (w_enq) begin
            r_mem[r_wptr] <= w_stg_data[c][s];
            r_wptr        <= ~r_wptr;
          end
          if (w_deq) begin
            r_rptr <= ~r_rptr;
          end
          r_count <= r_count + 2'(w_enq) - 2'(w_deq);
        end
      end

      assign w_stg_valid[c][s+1] = (r_count != 2'd0);
      assign w_stg_data[c][s+1]  = r_mem[r_rptr];
      assign w_stg_ready[c][s]   = (r_count != 2'd2);
    end

    assign w_stg_ready[c][stages_p]     = ready_and_i[c];
    assign valid_o[c]                   = w_stg_valid[c][stages_p];
    assign data_o[c*width_p +: width_p] = w_stg_data[c][stages_p];

    // Saturating stall counter; clear wins over a same-cycle increment.
    logic [SW-1:0] r_stall;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_stall <= '0;
      end else if (stall_clear_i) begin
        r_stall <= '0;
      end else if (valid_o[c] && !ready_and_i[c] && (r_stall != {SW{1'b1}})) begin
        r_stall <= r_stall + SW'(1);
      end
    end

    assign stall_cnt_o[c*SW +: SW] = r_stall;
  end

endmodule

// File: tb/tb_bsg_manycore_ruche_link_pipe.sv
// Bench for bsg_manycore_ruche_link_pipe: three configurations checked by
// directed scenarios plus a queue-based reference model under random traffic.
module tb_bsg_manycore_ruche_link_pipe;

  logic clk;
  logic rst_n;

  // Instance A: stages 2, rotate, 4-bit stall counters
  logic [5:0]  a_valid_i, a_ready_and_o, a_valid_o, a_ready_and_i;
  logic [47:0] a_data_i, a_data_o;
  logic        a_stall_clear;
  logic [23:0] a_stall_cnt;
  // Instance B: defaults (stages 1, rotate, 16-bit counters)
  logic [5:0]  b_valid_i, b_ready_and_o, b_valid_o, b_ready_and_i;
  logic [47:0] b_data_i, b_data_o;
  logic        b_stall_clear;
  logic [95:0] b_stall_cnt;
  // Instance C: stages 0, identity mapping
  logic [5:0]  c_valid_i, c_ready_and_o, c_valid_o, c_ready_and_i;
  logic [47:0] c_data_i, c_data_o;
  logic        c_stall_clear;
  logic [95:0] c_stall_cnt;

  bsg_manycore_ruche_link_pipe #(.width_p(8), .ruche_factor_p(3), .stages_p(2),
    .rotate_p(1), .stall_ctr_width_p(4)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .valid_i(a_valid_i), .data_i(a_data_i),
    .ready_and_o(a_ready_and_o), .valid_o(a_valid_o), .data_o(a_data_o),
    .ready_and_i(a_ready_and_i), .stall_clear_i(a_stall_clear), .stall_cnt_o(a_stall_cnt));

  bsg_manycore_ruche_link_pipe #(.width_p(8)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .valid_i(b_valid_i), .data_i(b_data_i),
    .ready_and_o(b_ready_and_o), .valid_o(b_valid_o), .data_o(b_data_o),
    .ready_and_i(b_ready_and_i), .stall_clear_i(b_stall_clear), .stall_cnt_o(b_stall_cnt));

  bsg_manycore_ruche_link_pipe #(.width_p(8), .ruche_factor_p(3), .stages_p(0),
    .rotate_p(0), .stall_ctr_width_p(16)) u_c (
    .clk_i(clk), .reset_n_i(rst_n), .valid_i(c_valid_i), .data_i(c_data_i),
    .ready_and_o(c_ready_and_o), .valid_o(c_valid_o), .data_o(c_data_o),
    .ready_and_i(c_ready_and_i), .stall_clear_i(c_stall_clear), .stall_cnt_o(c_stall_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  logic [7:0]  sb_q [18][$];
  int unsigned mdl_stall [18];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output lane i takes input lane i+1 (mod 3) when rotating; direction kept.
  function automatic int src_of(input int c, input bit rot);
    return rot ? 2 * (((c / 2) + 1) % 3) + (c % 2) : c;
  endfunction

  function automatic int dst_of(input int k, input bit rot);
    return rot ? 2 * (((k / 2) + 2) % 3) + (k % 2) : k;
  endfunction

  // One negedge model step: handshakes seen now complete on the next rising edge.
  task automatic sb_step(input int inst, input bit rot, input int depth, input int smax,
                         input int sw, input logic [5:0] vi, input logic [47:0] di,
                         input logic [5:0] ro, input logic [5:0] vo, input logic [47:0] dout,
                         input logic [5:0] ri, input logic clr, input logic [95:0] scnt);
    int q;
    for (int c = 0; c < 6; c++) begin
      q = inst * 6 + c;
      chk($sformatf("i%0d_c%0d_stall", inst, c), 32'(scnt >> (c * sw)) & 32'(smax), mdl_stall[q]);
      if (clr) mdl_stall[q] = 0;
      else if (vo[c] && !ri[c] && mdl_stall[q] < smax) mdl_stall[q]++;
      if (depth == 0) begin
        chk($sformatf("i%0d_c%0d_pass_v", inst, c), 32'(vo[c]), 32'(vi[src_of(c, rot)]));
        chk($sformatf("i%0d_c%0d_pass_r", inst, c), 32'(ro[src_of(c, rot)]), 32'(ri[c]));
      end
    end
    for (int k = 0; k < 6; k++)
      if (vi[k] && ro[k]) sb_q[inst * 6 + dst_of(k, rot)].push_back(di[k*8 +: 8]);
    for (int c = 0; c < 6; c++) begin
      q = inst * 6 + c;
      if (vo[c] && ri[c]) begin
        chk($sformatf("i%0d_c%0d_expect_pkt", inst, c), 32'(sb_q[q].size() > 0), 32'd1);
        if (sb_q[q].size() > 0)
          chk($sformatf("i%0d_c%0d_data", inst, c), 32'(dout[c*8 +: 8]), 32'(sb_q[q].pop_front()));
      end
      chk($sformatf("i%0d_c%0d_occupancy", inst, c), 32'(sb_q[q].size() <= 2 * depth), 32'd1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the instance-A stream on input channel 5 (feeds output channel 3).
  task automatic a_stream(output bit acc);
    @(negedge clk);
    acc = a_ready_and_o[5] & a_valid_i[5];
    @(posedge clk);
    #1;
    if (acc) a_data_i[47:40] = a_data_i[47:40] + 8'd1;
  endtask

  bit         acc;
  int         acc_cnt;
  logic [7:0] exp_d;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    a_valid_i = '0; a_data_i = '0; a_ready_and_i = '1; a_stall_clear = 1'b0;
    b_valid_i = '0; b_data_i = '0; b_ready_and_i = '1; b_stall_clear = 1'b0;
    c_valid_i = '0; c_data_i = '0; c_ready_and_i = '1; c_stall_clear = 1'b0;
    for (int i = 0; i < 18; i++) mdl_stall[i] = 0;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          for (int i = 0; i < 18; i++) begin
            sb_q[i].delete();
            mdl_stall[i] = 0;
          end
        end else begin
          sb_step(0, 1'b1, 2, 15, 4, a_valid_i, a_data_i, a_ready_and_o, a_valid_o, a_data_o,
                  a_ready_and_i, a_stall_clear, 96'(a_stall_cnt));
          sb_step(1, 1'b1, 1, 65535, 16, b_valid_i, b_data_i, b_ready_and_o, b_valid_o, b_data_o,
                  b_ready_and_i, b_stall_clear, b_stall_cnt);
          sb_step(2, 1'b0, 0, 65535, 16, c_valid_i, c_data_i, c_ready_and_o, c_valid_o, c_data_o,
                  c_ready_and_i, c_stall_clear, c_stall_cnt);
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_valid", 32'(a_valid_o), 32'h0);
    chk("rst_a_ready", 32'(a_ready_and_o), 32'h3f);
    chk("rst_a_stall", 32'(a_stall_cnt), 32'h0);
    chk("rst_b_valid", 32'(b_valid_o), 32'h0);
    chk("rst_b_ready", 32'(b_ready_and_o), 32'h3f);
    chk("rst_b_stall_zero", 32'(b_stall_cnt == 96'd0), 32'd1);
    chk("rst_c_valid", 32'(c_valid_o), 32'h0);
    chk("rst_c_stall_zero", 32'(c_stall_cnt == 96'd0), 32'd1);
    rst_n = 1'b1;
    cyc();

    // Single packet: B input ch2 -> output ch0 one cycle later
    b_valid_i[2] = 1'b1; b_data_i[23:16] = 8'hA5;
    @(negedge clk);
    chk("single_accept", 32'(b_ready_and_o[2]), 32'd1);
    cyc();
    b_valid_i = '0;
    @(negedge clk);
    chk("single_valid", 32'(b_valid_o), 32'h01);
    chk("single_data", 32'(b_data_o[7:0]), 32'hA5);
    cyc();
    @(negedge clk);
    chk("single_gone", 32'(b_valid_o), 32'h00);
    cyc();

    // Rotation at lane wrap: input ch1 -> output ch5 (rotate) / ch1 (identity)
    a_valid_i[1] = 1'b1; a_data_i[15:8] = 8'h3C;
    b_valid_i[1] = 1'b1; b_data_i[15:8] = 8'hC3;
    c_valid_i[1] = 1'b1; c_data_i[15:8] = 8'h5A;
    #1;
    chk("rot0_valid", 32'(c_valid_o), 32'h02);
    chk("rot0_data", 32'(c_data_o[15:8]), 32'h5A);
    cyc();
    a_valid_i = '0; b_valid_i = '0; c_valid_i = '0;
    @(negedge clk);
    chk("rot_b_valid", 32'(b_valid_o), 32'h20);
    chk("rot_b_data", 32'(b_data_o[47:40]), 32'hC3);
    chk("lat_a_early", 32'(a_valid_o), 32'h00);
    cyc();
    @(negedge clk);
    chk("rot_a_valid", 32'(a_valid_o), 32'h20);
    chk("rot_a_data", 32'(a_data_o[47:40]), 32'h3C);
    cyc(); cyc();

    // Full: output ch3 blocked, its source input ch5 streams continuously
    a_ready_and_i[3] = 1'b0;
    a_data_i[47:40]  = 8'h00;
    a_valid_i[5]     = 1'b1;
    acc_cnt = 0;
    repeat (10) begin
      a_stream(acc);
      acc_cnt += int'(acc);
    end
    chk("full_accepts", 32'(acc_cnt), 32'd4);
    chk("full_ready_low", 32'(a_ready_and_o[5]), 32'd0);
    chk("full_others_ready", 32'(a_ready_and_o & 6'h1f), 32'h1f);
    repeat (20) a_stream(acc);
    chk("stall_sat", 32'(a_stall_cnt[15:12]), 32'd15);
    a_stream(acc);
    chk("stall_sat_hold", 32'(a_stall_cnt[15:12]), 32'd15);
    a_stall_clear = 1'b1;
    a_stream(acc);
    a_stall_clear = 1'b0;
    chk("stall_clear", 32'(a_stall_cnt[15:12]), 32'd0);
    a_stream(acc);
    chk("stall_after_clear", 32'(a_stall_cnt[15:12]), 32'd1);
    a_ready_and_i[3] = 1'b1;
    exp_d = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("drain_v%0d", i), 32'(a_valid_o[3]), 32'd1);
      chk($sformatf("drain_d%0d", i), 32'(a_data_o[31:24]), 32'(exp_d));
      exp_d = exp_d + 8'd1;
      acc = a_ready_and_o[5];
      @(posedge clk);
      #1;
      if (acc) a_data_i[47:40] = a_data_i[47:40] + 8'd1;
    end
    a_valid_i = '0;
    repeat (5) cyc();

    // Reset mid-operation with three packets in flight
    a_ready_and_i = '0;
    a_valid_i = 6'b010101;
    a_data_i[7:0] = 8'h11; a_data_i[23:16] = 8'h22; a_data_i[39:32] = 8'h33;
    cyc();
    a_valid_i = '0;
    repeat (4) cyc();
    chk("pre_rst_stall_nonzero", 32'(a_stall_cnt != 24'd0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(a_valid_o), 32'h0);
    chk("async_rst_stall", 32'(a_stall_cnt), 32'h0);
    chk("async_rst_ready", 32'(a_ready_and_o), 32'h3f);
    a_ready_and_i = '1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    a_valid_i[0] = 1'b1; a_data_i[7:0] = 8'h77;
    @(negedge clk);
    chk("post_rst_accept", 32'(a_ready_and_o[0]), 32'd1);
    cyc();
    a_valid_i = '0;
    @(negedge clk);
    chk("post_rst_no_old", 32'(a_valid_o), 32'h00);
    cyc();
    @(negedge clk);
    chk("post_rst_valid", 32'(a_valid_o), 32'h10);
    chk("post_rst_data", 32'(a_data_o[39:32]), 32'h77);
    cyc(); cyc();

    // Random traffic on all three instances against the reference model
    repeat (1000) begin
      a_valid_i = 6'($urandom); a_data_i = 48'({$urandom, $urandom});
      a_ready_and_i = 6'($urandom | $urandom);
      a_stall_clear = ($urandom_range(0, 31) == 0);
      b_valid_i = 6'($urandom); b_data_i = 48'({$urandom, $urandom});
      b_ready_and_i = 6'($urandom);
      b_stall_clear = ($urandom_range(0, 31) == 0);
      c_valid_i = 6'($urandom); c_data_i = 48'({$urandom, $urandom});
      c_ready_and_i = 6'($urandom);
      c_stall_clear = ($urandom_range(0, 31) == 0);
      cyc();
    end
    a_valid_i = '0; b_valid_i = '0; c_valid_i = '0;
    a_ready_and_i = '1; b_ready_and_i = '1; c_ready_and_i = '1;
    a_stall_clear = 1'b0; b_stall_clear = 1'b0; c_stall_clear = 1'b0;
    repeat (8) cyc();
    for (int i = 0; i < 18; i++)
      chk($sformatf("drained_q%0d", i), 32'(sb_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
